load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, cycles in REQ+WAIT before abort (used only when LSU_TIMEOUT_EN is defined).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL have the following ports:
- i_clk  in  1  clock.
- i_rst  in  1  async active-high reset.
- i_valid  in  1  EX-stage memory op present.
- i_load  in  1  op is a load.
- i_store  in  1  op is a store.
- i_funct3  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- i_addr  in  32  effective address (ALU add result).
- i_wdata  in  32  store data (rs2).
- o_busy  out  1  op in flight, stalls upstream.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data, valid with o_done.
- o_err_align  out  1  misaligned/illegal op, pulses with o_done.
- o_fault  out  1  timeout abort, pulses with o_done.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  write request.
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wmask  out  4  byte write enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ready  in  1  request accepted this cycle.
- i_mem_valid  in  1  response/ack this cycle.
- i_mem_rdata  in  32  read word.

Function
REQ-004 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE, with all outputs registered.
REQ-005 In IDLE, i_valid & (i_load|i_store) SHALL capture addr/wdata/funct3/type; an aligned, legal op goes to REQ next cycle; i_valid with neither load nor store is ignored.
REQ-006 i_load & i_store together SHALL be treated as a load.
REQ-007 Misalignment SHALL be h/hu with addr[0]=1 or w with addr[1:0]≠0; illegal funct3 (011, 110, 111, or 1xx on store) is treated identically; either case issues no memory request and pulses o_done+o_err_align next cycle.
REQ-008 In REQ, o_mem_req SHALL stay high with stable addr/we/wmask/wdata until i_mem_ready; i_mem_ready moves to WAIT.
REQ-009 i_mem_ready & i_mem_valid in the same REQ cycle SHALL complete directly to IDLE.
REQ-010 In WAIT, i_mem_valid SHALL return to IDLE; o_done pulses the following cycle.
REQ-011 Best-case latency SHALL be: accept at cycle N, o_mem_req at N+1, o_done at N+2.
REQ-012 Loads SHALL produce o_rdata = (i_mem_rdata >> 8*addr[1:0]), sign-extended for b/h and zero-extended for bu/hu, registered on i_mem_valid and held until the next completion.
REQ-013 Stores SHALL drive wmask b=4'b0001<<addr[1:0], h=4'b0011<<addr[1:0], w=4'b1111, and wdata b={4{wdata[7:0]}}, h={2{wdata[15:0]}}, w=wdata.
REQ-014 o_mem_wmask SHALL be 0 when o_mem_we=0.
REQ-015 o_busy SHALL be high whenever state≠IDLE or o_done is pending.
REQ-016 i_valid while busy SHALL be ignored; upstream holds it.
REQ-017 i_mem_valid/i_mem_ready in IDLE SHALL be ignored.
REQ-018 Stores SHALL leave o_rdata unchanged.

Reset
REQ-019 i_rst SHALL asynchronously force IDLE and zero all outputs and captured registers (o_mem_req drops immediately, including mid-REQ/WAIT).
REQ-020 A response arriving after reset SHALL be ignored.

Configuration
REQ-021 With LSU_TIMEOUT_EN defined, a counter SHALL clear on entering REQ; if it reaches TIMEOUT_CYCLES before completion, the FSM returns to IDLE and o_done+o_fault pulse with o_rdata=0.
REQ-022 Without LSU_TIMEOUT_EN, o_fault SHALL be tied 0, no counter exists, and the FSM waits indefinitely.

Structure
REQ-023 Package lsu_pkg SHALL hold the funct3 size/sign localparams and the FSM state encoding.
REQ-024 The combinational load extraction/extension SHALL be a sub-module load_extend; the store lane logic stays inline.

Verification
REQ-025 lb from 0x1003 with rdata 0x80AABBCC -> o_mem_addr 0x1000, o_rdata 0xFFFFFF80, o_done at N+2 with ready=valid=1 at N+1.
REQ-026 sh wdata 0x1234ABCD to 0x2002 -> wmask 4'b1100, wdata 0xABCDABCD, we=1; ready delayed 3 cycles -> req held stable.
REQ-027 lw at 0x3001 -> no o_mem_req, o_done+o_err_align at N+1, o_busy high only for that cycle.
REQ-028 lhu at 0x4002 with rdata 0xF00D0000, ready at N+1, valid at N+4 -> o_rdata 0x0000F00D at N+5.
REQ-029 Assert i_rst in WAIT, then pulse i_mem_valid -> FSM IDLE, no o_done.
REQ-030 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert ready -> o_fault+o_done after 8 cycles; next op proceeds normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 size/sign codes
// and the request FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> REQ -> WAIT request FSM with registered outputs.
// Optional request timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err_align,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  // Memory handshake: o_mem_req with addr/we/wmask/wdata is held constant
  // until a cycle with i_mem_ready=1 (accept). The response is the first cycle
  // with i_mem_valid=1 at or after the accept cycle; both outside REQ/WAIT are ignored.

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        load_q;

  logic        accept;
  logic        op_ok;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic        mem_done;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .rdata    (i_mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (funct3_q),
    .data     (ext_data)
  );

  // o_busy is also high during the o_done cycle, which blocks a new accept there.
  assign accept = (state == ST_IDLE) && !o_busy && i_valid && (i_load || i_store);

  assign mem_done = ((state == ST_REQ) && i_mem_ready && i_mem_valid) ||
                    ((state == ST_WAIT) && i_mem_valid);

  // Legality/alignment of the incoming op; unsigned sizes exist only for loads.
  always_comb begin
    op_ok = 1'b0;
    case (i_funct3)
      F3_B:    op_ok = 1'b1;
      F3_H:    op_ok = ~i_addr[0];
      F3_W:    op_ok = (i_addr[1:0] == 2'b00);
      F3_BU:   op_ok = i_load;
      F3_HU:   op_ok = i_load && ~i_addr[0];
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = i_wdata;
    case (i_funct3)
      F3_B: begin
        st_mask  = 4'b0001 << i_addr[1:0];
        st_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        st_mask  = 4'b0011 << i_addr[1:0];
        st_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = i_wdata;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`else
  assign o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      load_q      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rdata     <= '0;
      o_err_align <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wmask <= '0;
      o_mem_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
      o_fault     <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      o_done      <= 1'b0;
      o_err_align <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      o_fault     <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          o_busy <= 1'b0;
          if (accept) begin
            addr_q   <= i_addr;
            funct3_q <= i_funct3;
            load_q   <= i_load;
            o_busy   <= 1'b1;
            if (!op_ok) begin
              o_done      <= 1'b1;
              o_err_align <= 1'b1;
            end else begin
              state       <= ST_REQ;
              o_mem_req   <= 1'b1;
              o_mem_we    <= ~i_load;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wmask <= i_load ? 4'b0000 : st_mask;
              o_mem_wdata <= i_load ? 32'h0 : st_wdata;
`ifdef LSU_TIMEOUT_EN
              cnt         <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (i_mem_ready) begin
            state       <= ST_WAIT;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wmask <= 4'b0000;
          end
        end
        default: ;
      endcase

      if (mem_done) begin
        state  <= ST_IDLE;
        o_done <= 1'b1;
        if (load_q) o_rdata <= ext_data;
      end
`ifdef LSU_TIMEOUT_EN
      else if (state != ST_IDLE) begin
        if (cnt == CNT_LAST) begin
          state       <= ST_IDLE;
          o_mem_req   <= 1'b0;
          o_mem_we    <= 1'b0;
          o_mem_wmask <= 4'b0000;
          o_done      <= 1'b1;
          o_fault     <= 1'b1;
          o_rdata     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, randomized ops
// against a behavioural model, reset and (with LSU_TIMEOUT_EN) timeout cases.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_load = 1'b0;
  logic        i_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err_align;
  logic        o_fault;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_load      (i_load),
    .i_store     (i_store),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_err_align (o_err_align),
    .o_fault     (o_fault),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wmask (o_mem_wmask),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_valid (i_mem_valid),
    .i_mem_rdata (i_mem_rdata)
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: outcome of one op from the ISA rules, in plain arithmetic.
  function automatic void model(input bit ld, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output bit err,
                                output logic [3:0] mask, output logic [31:0] wd,
                                output logic [31:0] rd);
    int size;
    int off;
    bit uns;
    bit legal;
    logic [63:0] v;
    logic [63:0] keep;
    size = 4; uns = 0; legal = 1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; legal = ld; end
      3'd5: begin size = 2; uns = 1; legal = ld; end
      default: legal = 0;
    endcase
    off = int'(addr % 32'd4);
    err = !legal || ((addr % 32'(size)) != 0);
    mask = ld ? 4'b0000 : 4'(((1 << size) - 1) << off);
    wd = '0;
    if (!ld)
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    keep = (64'd1 << (8 * size)) - 64'd1;
    v = (64'(rdata) >> (8 * off)) & keep;
    if (!uns && v[8*size-1]) v = v | ~keep;
    rd = v[31:0];
  endfunction

  // Drives one op and checks every cycle until it retires.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rdly, input int vdly,
                        input bit garbage);
    bit err;
    logic [3:0] emask;
    logic [31:0] ewd, erd;
    model(ld, f3, addr, wdata, rdata, err, emask, ewd, erd);
    exp_q.push_back(ld && !err ? erd : exp_rdata);
    i_valid = 1; i_load = ld; i_store = st; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    step();
    if (garbage) begin
      i_load = 1; i_store = 0; i_funct3 = 3'd0; i_addr = $urandom; i_wdata = $urandom;
    end else begin
      i_valid = 0;
    end
    if (err) begin
      void'(exp_q.pop_front());
      check("err_done", o_done, 1);
      check("err_flag", o_err_align, 1);
      check("err_noreq", o_mem_req, 0);
      check("err_busy", o_busy, 1);
      step();
      i_valid = 0;
      check("err_busy_clear", o_busy, 0);
      check("err_done_clear", o_done, 0);
      return;
    end
    for (int k = 0; k <= rdly; k++) begin
      check("req_high", o_mem_req, 1);
      check("req_addr", o_mem_addr, {addr[31:2], 2'b00});
      check("req_we", o_mem_we, {31'b0, !ld});
      check("req_wmask", o_mem_wmask, emask);
      check("req_busy", o_busy, 1);
      check("req_no_done", o_done, 0);
      if (!ld) check("req_wdata", o_mem_wdata, ewd);
      if (k == rdly) begin
        i_mem_ready = 1;
        i_mem_valid = (vdly == 0);
        i_mem_rdata = (vdly == 0) ? rdata : $urandom;
      end
      step();
    end
    i_mem_ready = 0;
    if (vdly > 0) begin
      i_mem_valid = 0;
      check("req_dropped", o_mem_req, 0);
      check("wait_wmask", o_mem_wmask, 0);
      for (int k = 0; k < vdly - 1; k++) begin
        check("wait_no_done", o_done, 0);
        step();
      end
      check("wait_no_done_last", o_done, 0);
      i_mem_valid = 1; i_mem_rdata = rdata;
      step();
    end
    i_mem_valid = 0; i_mem_rdata = $urandom;
    exp_rdata = exp_q.pop_front();
    check("done_pulse", o_done, 1);
    check("done_err", o_err_align, 0);
    check("done_fault", o_fault, 0);
    check("done_busy", o_busy, 1);
    check("done_rdata", o_rdata, exp_rdata);
    check("done_noreq", o_mem_req, 0);
    step();
    i_valid = 0;
    check("post_done_clear", o_done, 0);
    check("post_busy_clear", o_busy, 0);
  endtask

  task automatic reset_during(input bit in_wait);
    i_valid = 1; i_load = 1; i_store = 0; i_funct3 = 3'd2; i_addr = 32'h5000;
    step();
    i_valid = 0;
    if (in_wait) begin
      i_mem_ready = 1;
      step();
      i_mem_ready = 0;
    end else begin
      check("rst_req_before", o_mem_req, 1);
    end
    #2 i_rst = 1;
    #1;
    check("rst_async_req", o_mem_req, 0);
    check("rst_async_busy", o_busy, 0);
    check("rst_async_rdata", o_rdata, 0);
    step();
    i_rst = 0;
    exp_rdata = '0;
    i_mem_valid = 1; i_mem_ready = 1; i_mem_rdata = 32'hDEADBEEF;
    step();
    i_mem_valid = 0; i_mem_ready = 0;
    check("rst_late_resp_done", o_done, 0);
    check("rst_late_resp_busy", o_busy, 0);
    check("rst_late_resp_rdata", o_rdata, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_req", o_mem_req, 0);
    check("reset_rdata", o_rdata, 0);
    check("reset_fault", o_fault, 0);
    step();
    step();
    i_rst = 0;
    step();

    // lb from 0x1003, ready and valid together
    run_op(1, 0, 3'd0, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0);
    check("lb_vector_rdata", o_rdata, 32'hFFFFFF80);
    // sh to 0x2002 with ready delayed three cycles
    run_op(0, 1, 3'd1, 32'h2002, 32'h1234ABCD, 32'h0, 3, 0, 1);
    check("sh_keeps_rdata", o_rdata, 32'hFFFFFF80);
    // lw at 0x3001 misaligned
    run_op(1, 0, 3'd2, 32'h3001, 32'h0, 32'h0, 0, 0, 0);
    // lhu at 0x4002, valid three cycles after ready
    run_op(1, 0, 3'd5, 32'h4002, 32'h0, 32'hF00D0000, 0, 3, 0);
    check("lhu_vector_rdata", o_rdata, 32'h0000F00D);
    // load and store together acts as a load
    run_op(1, 1, 3'd4, 32'h7001, 32'hFFFFFFFF, 32'h00C30000, 1, 2, 1);
    // store with unsigned funct3 is illegal
    run_op(0, 1, 3'd4, 32'h8000, 32'h55, 32'h0, 0, 0, 0);

    // valid with neither load nor store is ignored
    i_valid = 1; i_load = 0; i_store = 0; i_funct3 = 3'd2; i_addr = 32'h9000;
    step();
    i_valid = 0;
    check("noop_busy", o_busy, 0);
    check("noop_req", o_mem_req, 0);
    step();
    check("noop_done", o_done, 0);

    // memory signals in IDLE are ignored
    i_mem_ready = 1; i_mem_valid = 1; i_mem_rdata = 32'h12345678;
    step();
    i_mem_ready = 0; i_mem_valid = 0;
    check("idle_mem_done", o_done, 0);
    check("idle_mem_busy", o_busy, 0);
    check("idle_mem_rdata", o_rdata, exp_rdata);

    // randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      bit ld, st;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef LSU_TIMEOUT_EN
    // request never accepted: abort after TO cycles in REQ/WAIT
    i_valid = 1; i_load = 1; i_store = 0; i_funct3 = 3'd2; i_addr = 32'h6000;
    step();
    i_valid = 0;
    for (int k = 0; k < TO; k++) begin
      check("to_pending_done", o_done, 0);
      check("to_pending_req", o_mem_req, 1);
      step();
    end
    exp_rdata = '0;
    check("to_done", o_done, 1);
    check("to_fault", o_fault, 1);
    check("to_rdata", o_rdata, 0);
    check("to_req_drop", o_mem_req, 0);
    step();
    check("to_busy_clear", o_busy, 0);
    run_op(1, 0, 3'd1, 32'h6002, 32'h0, 32'h80010000, 1, 1, 0);
`endif

    // reset in REQ, then in WAIT, with a late response
    reset_during(0);
    reset_during(1);
    run_op(1, 0, 3'd0, 32'hA001, 32'h0, 32'h0000F100, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
